// File: rtl/stereo_split_ctrl.sv
// Frame-lock FSM with col/row indices and left/right pair window for the side-by-side stereo split.
// Latency: dl_ce 0 cycles; col/row/pair_valid/de_d/sof/eol/line_err 1 cycle after the de_in sample.
// No backpressure: tracks the pixel clock every cycle. FRAME_CHECK_EN adds frame_err and err_cnt.
module stereo_split_ctrl #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int HALF_IMG_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic        dl_ce,
  output logic [10:0] col,
  output logic [9:0]  row,
  output logic        pair_valid,
  output logic        de_d,
  output logic        sof,
  output logic        eol,
  output logic        line_err,
  output logic        locked
`ifdef FRAME_CHECK_EN
  ,
  output logic        frame_err,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [10:0] W_L    = 11'(IMG_W);
  localparam logic [10:0] HALF_L = 11'(HALF_IMG_W);
  localparam logic [9:0]  ROW_MAX = 10'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VBLANK,
    S_HBLANK,
    S_ACTIVE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] pix_cnt;
  logic        pix_ovf;
  logic        cnt_en;
  logic        good_end;
  logic        bad_end;
  logic        row_clr;

  // Lines are delimited by de alone; h_sync carries no counting information.
  logic        unused_h_sync;
  assign unused_h_sync = h_sync_in;

  assign locked = (state == S_HBLANK) || (state == S_ACTIVE);
  assign dl_ce  = de_in & locked;

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    good_end  = 1'b0;
    bad_end   = 1'b0;
    row_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (v_sync_in) state_nxt = S_VBLANK;
      end
      S_VBLANK: begin
        if (!v_sync_in) begin
          row_clr = 1'b1;
          if (de_in) begin
            state_nxt = S_ACTIVE;
            cnt_en    = 1'b1;
          end else begin
            state_nxt = S_HBLANK;
          end
        end
      end
      S_HBLANK: begin
        if (v_sync_in) begin
          state_nxt = S_VBLANK;
        end else if (de_in) begin
          state_nxt = S_ACTIVE;
          cnt_en    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!de_in) begin
          // A line is good only with exactly IMG_W pixels; overflow is sticky until de falls.
          if (pix_cnt == W_L && !pix_ovf) begin
            good_end  = 1'b1;
            state_nxt = S_HBLANK;
          end else begin
            bad_end   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (v_sync_in) begin
          bad_end   = 1'b1;
          state_nxt = S_VBLANK;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      pix_ovf    <= 1'b0;
      col        <= '0;
      row        <= '0;
      pair_valid <= 1'b0;
      de_d       <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      de_d       <= de_in;
      eol        <= good_end;
      line_err   <= bad_end;
      pair_valid <= cnt_en & locked & (pix_cnt >= HALF_L);
      sof        <= cnt_en && (pix_cnt == 11'd0) && (row_clr || row == 10'd0);
      if (cnt_en) begin
        col <= pix_cnt;
        if (pix_cnt == W_L) pix_ovf <= 1'b1;
        else                pix_cnt <= pix_cnt + 11'd1;
      end else begin
        pix_cnt <= '0;
        pix_ovf <= 1'b0;
      end
      if (row_clr)       row <= '0;
      else if (good_end) row <= (row == ROW_MAX) ? 10'd0 : row + 10'd1;
    end
  end

`ifdef FRAME_CHECK_EN
  logic        v_sync_q;
  logic [10:0] line_cnt;
  logic        frame_bad;
  logic [8:0]  err_sum;

  // Only a frame that was tracked to its end (sitting in HBLANK) is judged.
  assign frame_bad = v_sync_in && !v_sync_q && (state == S_HBLANK) && (line_cnt != 11'(IMG_H));
  assign err_sum   = {1'b0, err_cnt} + {8'd0, bad_end} + {8'd0, frame_bad};

  always_ff @(posedge clk) begin
    if (rst) begin
      v_sync_q  <= 1'b0;
      line_cnt  <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      v_sync_q  <= v_sync_in;
      frame_err <= frame_bad;
      if (row_clr)                          line_cnt <= '0;
      else if (good_end && line_cnt != '1)  line_cnt <= line_cnt + 11'd1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_stereo_split_ctrl.sv
// Randomized stream of vblanks, lines and gaps checked per cycle against a line/frame-level model.
module tb_stereo_split_ctrl;
  localparam int W    = 64;
  localparam int H    = 64;
  localparam int HALF = 32;
  localparam int MAXC = 45000;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        dl_ce;
  logic [10:0] col;
  logic [9:0]  row;
  logic        pair_valid;
  logic        de_d;
  logic        sof;
  logic        eol;
  logic        line_err;
  logic        locked;
`ifdef FRAME_CHECK_EN
  logic        frame_err;
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  stereo_split_ctrl #(.IMG_W(W), .IMG_H(H), .HALF_IMG_W(HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .dl_ce      (dl_ce),
    .col        (col),
    .row        (row),
    .pair_valid (pair_valid),
    .de_d       (de_d),
    .sof        (sof),
    .eol        (eol),
    .line_err   (line_err),
    .locked     (locked)
`ifdef FRAME_CHECK_EN
    ,
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
`endif
  );

  // Stimulus per cycle and expected results: e_lk is the lock state during the cycle,
  // the other e_* arrays are registered outputs after that cycle's clock edge (-1 = hold).
  bit a_de [MAXC];
  bit a_vs [MAXC];
  bit a_hs [MAXC];
  bit e_lk [MAXC];
  bit e_pv [MAXC];
  bit e_sof [MAXC];
  bit e_eol [MAXC];
  bit e_lerr [MAXC];
  bit e_ferr [MAXC];
  int e_col [MAXC];
  int e_row [MAXC];

  int ncyc;
  bit m_lock;
  bit m_exit;
  int m_row;
  int m_lines;
  int n_checks;
  int n_fail;
  int cyc_now;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_now, got, exp);
    end
  endtask

  task automatic model_reset();
    ncyc    = 0;
    m_lock  = 1'b0;
    m_exit  = 1'b0;
    m_row   = 0;
    m_lines = 0;
  endtask

  task automatic put(input bit de, input bit vs, output int t);
    if (ncyc >= MAXC) begin
      $display("FAIL stim_overflow cycle=%0d got=%0d expected<%0d", ncyc, ncyc, MAXC);
      $fatal(1, "stimulus table full");
    end
    t = ncyc;
    ncyc++;
    a_de[t]   = de;
    a_vs[t]   = vs;
    a_hs[t]   = 1'($urandom_range(0, 1));
    e_lk[t]   = m_lock;
    e_col[t]  = -1;
    e_row[t]  = -1;
    e_pv[t]   = 1'b0;
    e_sof[t]  = 1'b0;
    e_eol[t]  = 1'b0;
    e_lerr[t] = 1'b0;
    e_ferr[t] = 1'b0;
    if (vs) begin
      m_lock = 1'b0;
      m_exit = 1'b1;
    end else if (m_exit) begin
      // first cycle after vblank: frame starts, lock from the next cycle on
      m_exit   = 1'b0;
      m_lock   = 1'b1;
      m_row    = 0;
      m_lines  = 0;
      e_row[t] = 0;
    end
  endtask

  task automatic gap(input int n);
    int t;
    for (int i = 0; i < n; i++) put(1'b0, 1'b0, t);
  endtask

  task automatic vblank(input int n);
    int t;
    bit fe;
    fe = m_lock && (m_lines != H);
    for (int i = 0; i < n; i++) begin
      put(1'b0, 1'b1, t);
      if (i == 0) e_ferr[t] = fe;
    end
  endtask

  task automatic pixels(input int len, input bit counted);
    int t;
    int c;
    for (int k = 0; k < len; k++) begin
      put(1'b1, 1'b0, t);
      if (counted) begin
        c        = (k < W) ? k : W;
        e_col[t] = c;
        e_pv[t]  = (c >= HALF);
        e_sof[t] = (k == 0) && (m_row == 0);
      end
    end
  endtask

  task automatic line(input int len, input int g);
    int t;
    bit counted;
    counted = m_lock;
    pixels(len, counted);
    put(1'b0, 1'b0, t);
    if (counted) begin
      if (len == W) begin
        e_eol[t] = 1'b1;
        m_row    = (m_row + 1) % H;
        e_row[t] = m_row;
        m_lines++;
      end else begin
        e_lerr[t] = 1'b1;
        m_lock    = 1'b0;
      end
    end
    gap(g - 1);
  endtask

  task automatic frame(input int nlines, input int gmin, input int gmax,
                       input int bad_idx, input int bad_len, input bit rnd_len);
    int len;
    for (int i = 0; i < nlines; i++) begin
      len = (i == bad_idx) ? bad_len : W;
      if (rnd_len && $urandom_range(0, 7) == 0) len = $urandom_range(1, 80);
      line(len, $urandom_range(gmin, gmax));
    end
  endtask

  task automatic execute();
    int col_m;
    int row_m;
`ifdef FRAME_CHECK_EN
    int ec_m;
    ec_m = 0;
`endif
    col_m = 0;
    row_m = 0;
    // reset lands in the middle of whatever line is on the bus
    @(posedge clk);
    #1;
    rst = 1'b1; de_in = 1'b1; v_sync_in = 1'b0; h_sync_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc_now = -1;
    check("rst_col", 32'(col), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_pair_valid", 32'(pair_valid), 32'd0);
    check("rst_de_d", 32'(de_d), 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_eol", 32'(eol), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_dl_ce", 32'(dl_ce), 32'd0);
`ifdef FRAME_CHECK_EN
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < ncyc && n_fail < 200; t++) begin
      cyc_now   = t;
      de_in     = a_de[t];
      v_sync_in = a_vs[t];
      h_sync_in = a_hs[t];
      @(negedge clk);
      check("locked", 32'(locked), 32'(e_lk[t]));
      check("dl_ce", 32'(dl_ce), 32'(a_de[t] & e_lk[t]));
      @(posedge clk);
      #1;
      if (e_col[t] >= 0) col_m = e_col[t];
      if (e_row[t] >= 0) row_m = e_row[t];
      check("col", 32'(col), 32'(col_m));
      check("row", 32'(row), 32'(row_m));
      check("pair_valid", 32'(pair_valid), 32'(e_pv[t]));
      check("de_d", 32'(de_d), 32'(a_de[t]));
      check("sof", 32'(sof), 32'(e_sof[t]));
      check("eol", 32'(eol), 32'(e_eol[t]));
      check("line_err", 32'(line_err), 32'(e_lerr[t]));
`ifdef FRAME_CHECK_EN
      ec_m = ec_m + int'(e_lerr[t]) + int'(e_ferr[t]);
      if (ec_m > 255) ec_m = 255;
      check("frame_err", 32'(frame_err), 32'(e_ferr[t]));
      check("err_cnt", 32'(err_cnt), 32'(ec_m));
`endif
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; de_in = 1'b0; v_sync_in = 1'b0; h_sync_in = 1'b0;
    n_checks = 0; n_fail = 0; cyc_now = 0;

    // stream joins mid-frame, then clean frames, short/long lines, a 63-line frame, random lines
    model_reset();
    for (int i = 0; i < 3; i++) line(W, 16);
    vblank(10); gap(5); frame(64, 16, 16, -1, 0, 1'b0);
    vblank(8);  gap(3); frame(64, 16, 16, -1, 0, 1'b0);
    vblank(6);  gap(2); frame(64, 16, 16, 10, 60, 1'b0);
    vblank($urandom_range(1, 12)); gap($urandom_range(1, 4)); frame(64, 1, 6, -1, 0, 1'b0);
    vblank($urandom_range(1, 12)); gap($urandom_range(1, 4)); frame(64, 1, 6, 5, 70, 1'b0);
    vblank($urandom_range(1, 12)); gap($urandom_range(1, 4)); frame(63, 1, 6, -1, 0, 1'b0);
    vblank($urandom_range(1, 12)); gap($urandom_range(1, 4)); frame(64, 1, 6, -1, 0, 1'b1);
    vblank(4); gap(2); pixels(20, m_lock);
    execute();

    // many short relocked lines to drive the error count into saturation
    model_reset();
    line(5, 2);
    line(W, 3);
    for (int i = 0; i < 260; i++) begin
      vblank($urandom_range(1, 3));
      gap($urandom_range(1, 2));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 70) : $urandom_range(1, 12);
      line(len, $urandom_range(1, 3));
    end
    gap(3);
    execute();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
